// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter for the shared single-port memory; optional MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins)
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Counter value on entering WAIT; zero means rvalid goes out on the first WAIT cycle.
    localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LAT - 1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_last, w_last_nxt;
    logic                r_sel, w_sel_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic                r_mem_en, w_mem_en_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic                r_gnt0, w_gnt0_nxt;
    logic                r_gnt1, w_gnt1_nxt;
    logic                r_rv0, w_rv0_nxt;
    logic                r_rv1, w_rv1_nxt;
    logic                r_busy, w_busy_nxt;
    logic                w_pick;

    // Winner of the IDLE sample: lone requester, else priority rule on a conflict.
    always_comb begin
        w_pick = 1'b0;
        if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w_pick = 1'b0;
`else
            w_pick = ~r_last;
`endif
        end else if (m1_req) begin
            w_pick = 1'b1;
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_sel_nxt       = r_sel;
        w_we_nxt        = r_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_gnt0_nxt      = 1'b0;
        w_gnt1_nxt      = 1'b0;
        w_rv0_nxt       = 1'b0;
        w_rv1_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    w_state_nxt     = S_ISSUE;
                    w_sel_nxt       = w_pick;
                    w_last_nxt      = w_pick;
                    w_we_nxt        = w_pick ? m1_we : m0_we;
                    w_mem_addr_nxt  = w_pick ? m1_addr : m0_addr;
                    w_mem_wdata_nxt = w_pick ? m1_wdata : m0_wdata;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_pick ? m1_we : m0_we;
                    w_gnt0_nxt      = ~w_pick;
                    w_gnt1_nxt      = w_pick;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LP_CNT_INIT;
                    if (LP_CNT_INIT == 4'd0) begin
                        w_rv0_nxt = ~r_sel;
                        w_rv1_nxt = r_sel;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_rv0_nxt = ~r_sel;
                        w_rv1_nxt = r_sel;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, latched request and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rv0       <= 1'b0;
            r_rv1       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_sel       <= w_sel_nxt;
            r_we        <= w_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_rv0       <= w_rv0_nxt;
            r_rv1       <= w_rv1_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign m0_gnt    = r_gnt0;
    assign m1_gnt    = r_gnt1;
    assign m0_rvalid = r_rv0;
    assign m1_rvalid = r_rv1;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter: vector table, corner sequences, randomized model
module tb_mem_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory device: data for an access in cycle c is presented in cycle c+LAT.
    bit [15:0] emu_ram [0:65535];
    bit [15:0] rd_pipe [0:15];
    assign mem_rdata = rd_pipe[LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) emu_ram[mem_addr] <= mem_wdata;
        for (int i = 15; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && !mem_we) ? emu_ram[mem_addr] : 16'hDEAD;
    end

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t      vt [8];
    bit [15:0] ref_ram [0:65535];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic r, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p != 0) ? m1_gnt : m0_gnt;
    endfunction

    function automatic logic rv_of(input int p);
        return (p != 0) ? m1_rvalid : m0_rvalid;
    endfunction

    function automatic logic [15:0] rdata_of(input int p);
        return (p != 0) ? m1_rdata : m0_rdata;
    endfunction

    function automatic int win_conflict(input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        set_req(v.port, 1, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk($sformatf("v%0d gnt", idx), gnt_of(v.port), 1);
        chk($sformatf("v%0d other gnt", idx), gnt_of(1 - v.port), 0);
        chk($sformatf("v%0d mem_en", idx), mem_en, 1);
        chk($sformatf("v%0d mem_we", idx), mem_we, v.we);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
        if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        set_req(v.port, 0, 0, 0, 0);
        if (!v.we) begin
            for (int c = 1; c < LAT; c++) begin
                @(negedge clk);
                chk($sformatf("v%0d early rvalid", idx), {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, mem_en}, 0);
                chk($sformatf("v%0d addr hold", idx), mem_addr, v.addr);
            end
            @(negedge clk);
            chk($sformatf("v%0d rvalid", idx), rv_of(v.port), 1);
            chk($sformatf("v%0d other rvalid", idx), rv_of(1 - v.port), 0);
            chk($sformatf("v%0d rdata", idx), rdata_of(v.port), v.exp_rdata);
        end
        @(negedge clk);
        chk($sformatf("v%0d busy after", idx), busy, 0);
        chk($sformatf("v%0d quiet after", idx), {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, mem_en}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        vt[0] = '{1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        vt[1] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vt[2] = '{1, 1'b1, 16'h0200, 16'h1234, 16'h0000};
        vt[3] = '{0, 1'b0, 16'h0200, 16'h0000, 16'h1234};
        vt[4] = '{1, 1'b0, 16'h0200, 16'h0000, 16'h1234};
        vt[5] = '{0, 1'b1, 16'h0004, 16'hA5A5, 16'h0000};
        vt[6] = '{1, 1'b0, 16'h0004, 16'h0000, 16'hA5A5};
        vt[7] = '{0, 1'b0, 16'h0300, 16'h0000, 16'h0000};

        // Reset and idle behaviour
        rst = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset flags", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy}, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= mem_en | busy | m0_gnt | m1_gnt;
        end
        chk("idle quiet", seen, 0);

        // Single transactions from a vector table
        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Reset during WAIT discards the read
        set_req(0, 1, 0, 16'h0010, 0);
        @(negedge clk);
        chk("rst-wait gnt", m0_gnt, 1);
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst-wait busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("rst-wait async clear", {busy, mem_en, m0_rvalid, m1_rvalid, m0_gnt}, 0);
        chk("rst-wait addr clear", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (LAT + 3) begin
            @(negedge clk);
            seen |= m0_rvalid | m1_rvalid | mem_en;
        end
        chk("rst-wait no rvalid", seen, 0);
        run_vec(vt[6], 8);

        // Both ports reading back-to-back
        do_reset();
        begin
            int order [4];
            int ng = 0;
            int overlap = 0;
            bit rd_open = 0;
            order = '{9, 9, 9, 9};
            set_req(0, 1, 0, 16'h0010, 0);
            set_req(1, 1, 0, 16'h0200, 0);
            for (int c = 0; c < 100 && ng < 4; c++) begin
                @(negedge clk);
                if (m0_gnt && m1_gnt) overlap++;
                if (m0_gnt || m1_gnt) begin
                    if (rd_open) overlap++;
                    order[ng] = m1_gnt ? 1 : 0;
                    ng++;
                    rd_open = 1;
                    set_req(m1_gnt ? 1 : 0, 0, 0, 0, 0);
                end
                if (m0_rvalid) begin
                    rd_open = 0;
                    chk("rr m0 rdata", m0_rdata, 16'hBEEF);
                    set_req(0, 1, 0, 16'h0010, 0);
                end
                if (m1_rvalid) begin
                    rd_open = 0;
                    chk("rr m1 rdata", m1_rdata, 16'h1234);
                    set_req(1, 1, 0, 16'h0200, 0);
                end
            end
            set_req(0, 0, 0, 0, 0);
            set_req(1, 0, 0, 0, 0);
            begin
                int lst = 1;
                for (int i = 0; i < 4; i++) begin
                    int w;
                    w = win_conflict(lst);
                    chk($sformatf("rr order %0d", i), order[i], w);
                    lst = w;
                end
            end
            chk("rr overlap", overlap, 0);
            repeat (LAT + 3) @(negedge clk);
        end

        // Both ports writing continuously, then port 0 drops out
        do_reset();
        set_req(0, 1, 1, 16'h0301, 16'h1111);
        set_req(1, 1, 1, 16'h0302, 16'h2222);
        begin
            int lst = 1;
            for (int j = 1; j <= 8; j++) begin
                int w;
                @(negedge clk);
                w = -1;
                if (j % 2 == 1) begin
                    w = win_conflict(lst);
                    lst = w;
                end
                chk($sformatf("wr j%0d m0_gnt", j), m0_gnt, w == 0);
                chk($sformatf("wr j%0d m1_gnt", j), m1_gnt, w == 1);
            end
        end
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wr drop m1_gnt", m1_gnt, 1);
        chk("wr drop m0_gnt", m0_gnt, 0);
        set_req(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("wr drop busy", busy, 0);

        // Randomized traffic against a transaction-level timing model
        do_reset();
        begin
            int          next_idle = 0;
            int          g_cyc = -1;
            int          g_port = 0;
            int          rv_cyc = -1;
            int          rv_port = 0;
            logic        g_we = 0;
            logic [15:0] g_addr = 0, g_wd = 0, rv_data = 0;
            int          m_last = 1;
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                chk("rnd m0_gnt", m0_gnt, (k == g_cyc) && (g_port == 0));
                chk("rnd m1_gnt", m1_gnt, (k == g_cyc) && (g_port == 1));
                chk("rnd mem_en", mem_en, k == g_cyc);
                chk("rnd m0_rvalid", m0_rvalid, (k == rv_cyc) && (rv_port == 0));
                chk("rnd m1_rvalid", m1_rvalid, (k == rv_cyc) && (rv_port == 1));
                chk("rnd busy", busy, (g_cyc >= 0) && (k >= g_cyc) && (k < next_idle));
                if (k == g_cyc) begin
                    chk("rnd mem_we", mem_we, g_we);
                    chk("rnd mem_addr", mem_addr, g_addr);
                    if (g_we) chk("rnd mem_wdata", mem_wdata, g_wd);
                end
                if (k == rv_cyc) chk("rnd rdata", rdata_of(rv_port), rv_data);
                for (int p = 0; p < 2; p++) begin
                    logic rq;
                    rq = (p != 0) ? m1_req : m0_req;
                    if (rq && gnt_of(p))
                        set_req(p, 0, 0, 0, 0);
                    else if (rq && $urandom_range(0, 15) == 0)
                        set_req(p, 0, 0, 0, 0);
                    else if (!rq && $urandom_range(0, 2) == 0)
                        set_req(p, 1, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom));
                end
                if (k >= next_idle && (m0_req || m1_req)) begin
                    int w;
                    if (m0_req && m1_req) w = win_conflict(m_last);
                    else w = m1_req ? 1 : 0;
                    m_last = w;
                    g_cyc  = k + 1;
                    g_port = w;
                    g_we   = (w != 0) ? m1_we : m0_we;
                    g_addr = (w != 0) ? m1_addr : m0_addr;
                    g_wd   = (w != 0) ? m1_wdata : m0_wdata;
                    if (g_we) begin
                        ref_ram[g_addr] = g_wd;
                        next_idle = g_cyc + 1;
                    end else begin
                        rv_cyc    = g_cyc + LAT;
                        rv_port   = w;
                        rv_data   = ref_ram[g_addr];
                        next_idle = g_cyc + LAT + 1;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
